key_spi_master: RTL and testbench
=================================

# key_spi_master

SPI initiator on the game side that polls the keypad board's key responder and decodes its key byte. Periodically runs one frame (load pulse with chip select low, then shift pulses with chip select high), collects the returned byte and presents a held key state plus a one-cycle new-press strobe to the Tetris game logic.

## Interface
- CLK_DIV, 8: clk cycles per sclk half-period; minimum 4.
- POLL_CYCLES, 65536: clk cycles between frame starts; must exceed 20*CLK_DIV+4.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  allow new frames to start; a frame in progress always completes.
- sclk  out  1  SPI clock to the keypad board; idles low.
- cs  out  1  chip select; low = responder loads its key byte, high = responder shifts; idles high.
- mosi  out  1  data to the responder; constant 0.
- miso  in  1  data from the responder; asynchronous to clk.
- key_code  out  4  last valid key code.
- key_down  out  1  a key was held in the last valid frame.
- key_press  out  1  one-cycle strobe: new press or changed key.
- frame_valid  out  1  one-cycle strobe: a well-formed byte was accepted.
- frame_err  out  1  one-cycle strobe: a malformed byte was discarded.
- busy  out  1  frame in progress.

## Operation
- Reset: sclk=0, cs=1, mosi=0, key_code=4'h0, key_down=0, key_press=0, frame_valid=0, frame_err=0, busy=0. Poll counter=0, FSM=IDLE, shift register=0.
- Poll counter increments every clk while enable=1, wraps at POLL_CYCLES-1. A frame starts when it wraps and FSM=IDLE. With enable=0 the counter holds.
- sclk cycle = CLK_DIV clk low, then CLK_DIV clk high.
- FSM states:
  - IDLE
  - LOAD: cs=0 for exactly one sclk cycle.
  - SHIFT: cs=1 from the start of this state; 9 sclk cycles; sclk ends low.
  - DONE: 1 clk; decode; then IDLE.
- Sampling:
  - miso passes through a 2-FF synchroniser.
  - The synchronised value is captured on the clk where sclk is driven 1->0.
  - The SHIFT cycle-1 sample is discarded. This is the responder's pipeline delay.
  - Samples from SHIFT cycles 2..9 are bits 7..0, MSB first.
- Decode of received byte rx:
  - rx==8'h0D: released. frame_valid=1, key_down<=0, key_code<=4'hD.
  - rx[7:4]==4'b1000 and rx[3:0]!=4'hD: pressed. frame_valid=1, key_down<=1, key_code<=rx[3:0].
  - key_press=1 on a pressed decode if the previous key_down was 0 or rx[3:0] differs from the previous key_code.
  - Any other rx: frame_err=1; key_code and key_down hold.
- busy=1 from the first LOAD cycle through DONE inclusive.
- enable may fall mid-frame; the frame completes normally.

## Timing
- Frame length: 20*CLK_DIV clk from LOAD entry to DONE, plus 1 clk for DONE.
- Strobes: exactly 1 clk wide, asserted in the cycle after DONE. key_code and key_down change in that same cycle.
- cs changes only while sclk=0. sclk has no glitches; all outputs are registered.
- miso-to-capture latency: 2 clk. CLK_DIV>=4 guarantees sampling at least 2 clk after the responder's falling-edge update.
- Asynchronous reset mid-frame: immediate return to reset values (cs=1, sclk=0). The next frame starts after a full POLL_CYCLES.

## Structure
- Package tetris_key_pkg:
  - KEY_NONE=4'hD
  - state enum {IDLE, LOAD, SHIFT, DONE}
  - SHIFT_BITS=9
  - field constants for byte bit 7 (pressed flag) and bits 6:4 (must be zero).
- Sub-module miso_sync: 2-FF synchroniser with asynchronous active-low reset, output reset 0.
- Top level holds the poll counter, half-period counter, bit counter, FSM, 8-bit shift register and decode.

## Test plan
- Responder model returns 0x83 (key 3):
  - Exactly one key_press and one frame_valid strobe.
  - key_code=4'h3, key_down=1.
  - 1 LOAD + 9 SHIFT sclk cycles observed; cs low only during LOAD.
- Same key 0x83 on the next frame:
  - frame_valid=1, key_press stays 0.
- Then 0x87 (key 7):
  - key_press=1, key_code=4'h7.
- Returns 0x0D:
  - key_down=0, key_code=4'hD, no key_press.
- miso stuck at 1 (0xFF), then 0x00:
  - frame_err=1 each time.
  - key_code and key_down unchanged.
- reset pulsed low mid-SHIFT:
  - All outputs return to reset values within the same cycle.
  - No strobe; next frame begins POLL_CYCLES after release.
- enable=0 during a frame:
  - Frame completes and decodes.
  - No further frame starts until enable=1.

Source files
------------

// File: rtl/tetris_key_pkg.sv
// Shared constants, state encoding and key-byte classification for the
// keypad SPI initiator.
package tetris_key_pkg;

  // Key code reported while no key is held.
  localparam logic [3:0] KEY_NONE = 4'hD;

  // SHIFT lasts this many sclk cycles. The first sample is the responder's
  // pipeline slot and falls off the top of the 8-bit shift register.
  localparam int unsigned SHIFT_BITS = 9;

  // Field positions inside the received key byte.
  localparam int unsigned PRESSED_BIT = 7;
  localparam int unsigned ZERO_MSB    = 6;
  localparam int unsigned ZERO_LSB    = 4;

  // Byte sent by the responder when no key is held.
  localparam logic [7:0] RELEASED_BYTE = {4'h0, KEY_NONE};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    RX_RELEASED,
    RX_PRESSED,
    RX_BAD
  } rx_kind_e;

  // Classify a received byte as released, pressed or malformed.
  function automatic rx_kind_e classify(input logic [7:0] rx);
    if (rx == RELEASED_BYTE) begin
      return RX_RELEASED;
    end
    if (rx[PRESSED_BIT] && (rx[ZERO_MSB:ZERO_LSB] == 3'b000) &&
        (rx[3:0] != KEY_NONE)) begin
      return RX_PRESSED;
    end
    return RX_BAD;
  endfunction

endpackage

// File: rtl/key_spi_master_miso_sync.sv
// Two-flop synchroniser bringing the responder's miso into the clk domain.
module miso_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture chain; output resets low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_spi_master.sv
// SPI initiator polling the keypad responder: periodic LOAD + SHIFT frame,
// byte collection and key decode with held state and one-cycle strobes.
module key_spi_master
  import tetris_key_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 8,
  parameter int unsigned POLL_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso,
  output logic [3:0] key_code,
  output logic       key_down,
  output logic       key_press,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(CLK_DIV - 1);
  localparam logic [3:0]        SHIFT_LAST = 4'(SHIFT_BITS - 1);

  state_e            state_q, state_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [3:0]        bit_q, bit_d;
  logic [7:0]        sr_q, sr_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_down_q, key_down_d;
  logic              key_press_q, key_press_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;

  logic              miso_s;
  logic              half_end;
  logic              sclk_fall;

  miso_sync u_miso_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (miso),
    .q     (miso_s)
  );

  // State and output registers; asynchronous return to the idle bus state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      poll_q        <= '0;
      half_q        <= '0;
      bit_q         <= '0;
      sr_q          <= '0;
      sclk_q        <= 1'b0;
      cs_q          <= 1'b1;
      busy_q        <= 1'b0;
      key_code_q    <= 4'h0;
      key_down_q    <= 1'b0;
      key_press_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      poll_q        <= poll_d;
      half_q        <= half_d;
      bit_q         <= bit_d;
      sr_q          <= sr_d;
      sclk_q        <= sclk_d;
      cs_q          <= cs_d;
      busy_q        <= busy_d;
      key_code_q    <= key_code_d;
      key_down_q    <= key_down_d;
      key_press_q   <= key_press_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Poll timer, sclk generation, bit sequencing, sampling and decode.
  always_comb begin
    state_d       = state_q;
    poll_d        = poll_q;
    half_d        = half_q;
    bit_d         = bit_q;
    sr_d          = sr_q;
    sclk_d        = sclk_q;
    key_code_d    = key_code_q;
    key_down_d    = key_down_q;
    key_press_d   = 1'b0;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    half_end  = (half_q == HALF_LAST);
    sclk_fall = half_end && sclk_q;

    if (enable) begin
      poll_d = (poll_q == POLL_LAST) ? '0 : poll_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (enable && (poll_q == POLL_LAST)) begin
          state_d = LOAD;
          half_d  = '0;
          sclk_d  = 1'b0;
        end
      end

      LOAD: begin
        half_d = half_end ? '0 : half_q + 1'b1;
        if (half_end) begin
          sclk_d = ~sclk_q;
        end
        if (sclk_fall) begin
          state_d = SHIFT;
          bit_d   = '0;
        end
      end

      SHIFT: begin
        half_d = half_end ? '0 : half_q + 1'b1;
        if (half_end) begin
          sclk_d = ~sclk_q;
        end
        // Nine shifts into eight bits: the pipeline-slot sample drops out
        // of the top, leaving bits 7..0 in place when DONE is reached.
        if (sclk_fall) begin
          sr_d = {sr_q[6:0], miso_s};
          if (bit_q == SHIFT_LAST) begin
            state_d = DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        unique case (classify(sr_q))
          RX_RELEASED: begin
            frame_valid_d = 1'b1;
            key_down_d    = 1'b0;
            key_code_d    = KEY_NONE;
          end
          RX_PRESSED: begin
            frame_valid_d = 1'b1;
            key_down_d    = 1'b1;
            key_code_d    = sr_q[3:0];
            key_press_d   = !key_down_q || (sr_q[3:0] != key_code_q);
          end
          default: begin
            frame_err_d = 1'b1;
          end
        endcase
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Derived from the next state so both bus pins stay registered.
    cs_d   = (state_d != LOAD);
    busy_d = (state_d != IDLE);
  end

  assign sclk        = sclk_q;
  assign cs          = cs_q;
  assign mosi        = 1'b0;
  assign key_code    = key_code_q;
  assign key_down    = key_down_q;
  assign key_press   = key_press_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_key_spi_master.sv
// Scoreboard bench for key_spi_master with a behavioural keypad responder.
module tb_key_spi_master;

  localparam int CLK_DIV     = 4;
  localparam int POLL_CYCLES = 200;

  typedef struct packed {
    logic       valid;
    logic       err;
    logic       press;
    logic [3:0] code;
    logic       down;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       miso = 1'b0;
  logic       sclk, cs, mosi;
  logic [3:0] key_code;
  logic       key_down, key_press, frame_valid, frame_err, busy;

  exp_t       exp_q[$];
  exp_t       exp_cur;
  exp_t       act_cur;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] resp_byte = 8'h00;
  logic [7:0] out_sr = 8'h00;
  logic       cs_at_rise = 1'b0;

  logic       check_shape = 1'b1;
  int         lo_rises = 0;
  int         hi_rises = 0;
  int         cs_lo_clks = 0;
  int         cs_stray = 0;
  logic       busy_prev = 1'b0;
  logic       sclk_prev = 1'b0;

  key_spi_master #(
    .CLK_DIV     (CLK_DIV),
    .POLL_CYCLES (POLL_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sclk        (sclk),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .key_code    (key_code),
    .key_down    (key_down),
    .key_press   (key_press),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  // Responder: loads its byte on an sclk rise with cs low, then presents the
  // next bit after each falling edge of a cs-high sclk cycle.
  initial begin
    forever begin
      @(posedge sclk);
      cs_at_rise = cs;
      if (!cs) out_sr = resp_byte;
      @(negedge sclk);
      if (cs_at_rise) begin
        #1;
        miso   = out_sr[7];
        out_sr = {out_sr[6:0], 1'b0};
      end
    end
  end

  // Monitor: pops expectations on strobes and checks the shape of each frame.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_valid || frame_err) begin
        checks++;
        act_cur = {frame_valid, frame_err, key_press, key_code, key_down};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected got v=%b e=%b p=%b code=%h down=%b required none",
                   frame_valid, frame_err, key_press, key_code, key_down);
        end else begin
          exp_cur = exp_q.pop_front();
          if (act_cur !== exp_cur) begin
            errors++;
            $display("FAIL decode got v=%b e=%b p=%b code=%h down=%b required v=%b e=%b p=%b code=%h down=%b",
                     act_cur.valid, act_cur.err, act_cur.press, act_cur.code, act_cur.down,
                     exp_cur.valid, exp_cur.err, exp_cur.press, exp_cur.code, exp_cur.down);
          end
        end
      end else if (key_press) begin
        checks++;
        errors++;
        $display("FAIL press_alone got key_press=1 required 0 without frame_valid");
      end

      if (busy && !busy_prev) begin
        lo_rises   = 0;
        hi_rises   = 0;
        cs_lo_clks = 0;
      end
      if (busy) begin
        if (sclk && !sclk_prev) begin
          if (cs) hi_rises++;
          else    lo_rises++;
        end
        if (!cs) cs_lo_clks++;
      end else if (cs !== 1'b1) begin
        cs_stray++;
      end
      if (!busy && busy_prev && check_shape) begin
        checks++;
        if (lo_rises != 1 || hi_rises != 9 || cs_lo_clks != 2 * CLK_DIV ||
            sclk !== 1'b0 || cs !== 1'b1) begin
          errors++;
          $display("FAIL frame_shape got load=%0d shift=%0d cs_low_clks=%0d sclk=%b cs=%b required 1 9 %0d 0 1",
                   lo_rises, hi_rises, cs_lo_clks, sclk, cs, 2 * CLK_DIV);
        end
      end
      busy_prev = busy;
      sclk_prev = sclk;
    end
  end

  function automatic exp_t mk(input logic v, input logic er, input logic p,
                              input logic [3:0] c, input logic d);
    return {v, er, p, c, d};
  endfunction

  task automatic wait_start(output int cyc);
    cyc = 0;
    while (busy !== 1'b1 && cyc < 4 * POLL_CYCLES) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (busy !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL start_timeout got busy=%b after %0d clk required 1", busy, cyc);
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40 * CLK_DIV) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL end_timeout got busy=%b required 0", busy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL strobe_missing got pending=%0d required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic run_frame(input logic [7:0] b, input exp_t e, input int start_cyc);
    int c;
    resp_byte = b;
    exp_q.push_back(e);
    wait_start(c);
    if (start_cyc > 0) begin
      checks++;
      if (c != start_cyc) begin
        errors++;
        $display("FAIL start_delay got %0d clk required %0d", c, start_cyc);
      end
    end
    wait_end();
  endtask

  initial begin
    int c;
    int n;
    int seen;

    reset  = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({sclk, cs, mosi, key_code, key_down, key_press, frame_valid, frame_err, busy} !== 12'b010_0000_00000) begin
      errors++;
      $display("FAIL reset_state got sclk=%b cs=%b mosi=%b code=%h down=%b p=%b v=%b e=%b busy=%b required 0 1 0 0 0 0 0 0 0",
               sclk, cs, mosi, key_code, key_down, key_press, frame_valid, frame_err, busy);
    end
    reset = 1'b1;

    run_frame(8'h83, mk(1'b1, 1'b0, 1'b1, 4'h3, 1'b1), POLL_CYCLES);
    run_frame(8'h83, mk(1'b1, 1'b0, 1'b0, 4'h3, 1'b1), 0);
    run_frame(8'h87, mk(1'b1, 1'b0, 1'b1, 4'h7, 1'b1), 0);
    run_frame(8'h0D, mk(1'b1, 1'b0, 1'b0, 4'hD, 1'b0), 0);
    run_frame(8'hFF, mk(1'b0, 1'b1, 1'b0, 4'hD, 1'b0), 0);
    run_frame(8'h00, mk(1'b0, 1'b1, 1'b0, 4'hD, 1'b0), 0);
    run_frame(8'h8D, mk(1'b0, 1'b1, 1'b0, 4'hD, 1'b0), 0);
    run_frame(8'h95, mk(1'b0, 1'b1, 1'b0, 4'hD, 1'b0), 0);
    run_frame(8'h80, mk(1'b1, 1'b0, 1'b1, 4'h0, 1'b1), 0);
    run_frame(8'h8F, mk(1'b1, 1'b0, 1'b1, 4'hF, 1'b1), 0);

    // Reset pulsed while the frame is in SHIFT.
    resp_byte = 8'h83;
    wait_start(c);
    n = 0;
    while (!(busy === 1'b1 && cs === 1'b1) && n < 40 * CLK_DIV) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (10) @(posedge clk);
    #1;
    check_shape = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({sclk, cs, mosi, key_code, key_down, key_press, frame_valid, frame_err, busy} !== 12'b010_0000_00000) begin
      errors++;
      $display("FAIL reset_midframe got sclk=%b cs=%b mosi=%b code=%h down=%b p=%b v=%b e=%b busy=%b required 0 1 0 0 0 0 0 0 0",
               sclk, cs, mosi, key_code, key_down, key_press, frame_valid, frame_err, busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_shape = 1'b1;
    run_frame(8'h83, mk(1'b1, 1'b0, 1'b1, 4'h3, 1'b1), POLL_CYCLES);

    // enable dropped mid-frame: the frame still decodes, then polling stops.
    resp_byte = 8'h85;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 4'h5, 1'b1));
    wait_start(c);
    repeat (20) @(posedge clk);
    #1;
    enable = 1'b0;
    wait_end();
    seen = 0;
    repeat (3 * POLL_CYCLES) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || cs !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL disabled_idle got %0d busy cycles required 0", seen);
    end
    enable = 1'b1;
    run_frame(8'h85, mk(1'b1, 1'b0, 1'b0, 4'h5, 1'b1), 0);

    checks++;
    if (cs_stray != 0) begin
      errors++;
      $display("FAIL cs_outside_frame got %0d cycles required 0", cs_stray);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
